// File: rtl/digit_serial_addsub_if.sv
// Start/busy/done handshake bundle for the digit-serial adder/subtractor.
// The requester drives operands, the adder returns the result and flags.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, x, y,
    input  busy, done, sum,
    input  carry_out, overflow,
    input  zero, negative
  );

  modport slave (
    input  start, sub, x, y,
    output busy, done, sum,
    output carry_out, overflow,
    output zero, negative
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement add/sub, DIGIT bits per cycle, LSB first.
// Result and flags are registered and held until the next completion.
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic clk,
  input  logic rst_b,
  digit_serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic [DIGIT:0]   step;
  logic             msb_cin;
  logic             last;
  logic             load;

  assign step = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  // carry into the top bit of this digit, meaningful on the last digit
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1]
                 ^ step[DIGIT-1];

  assign res_d = (res_q >> DIGIT)
               | (WIDTH'(step[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign last = (cnt_q == CW'(NDIG - 1));
  assign load = bus.start
              && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q     <= bus.x;
        b_q     <= bus.sub ? ~bus.y : bus.y;
        carry_q <= bus.sub;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        res_q   <= res_d;
        carry_q <= step[DIGIT];
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          sum_q  <= res_d;
          cout_q <= step[DIGIT];
          ovf_q  <= step[DIGIT] ^ msb_cin;
          zero_q <= (res_d == '0);
          neg_q  <= res_d[WIDTH-1];
        end
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub across four width/digit configs.
// Flags are compared as {carry_out, overflow, zero, negative}.
module tb_digit_serial_addsub;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  st = '0;
  logic        s = 1'b0;
  logic [31:0] xv = '0;
  logic [31:0] yv = '0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  digit_serial_addsub_if #(.WIDTH(8))  i0 ();
  digit_serial_addsub_if #(.WIDTH(16)) i1 ();
  digit_serial_addsub_if #(.WIDTH(8))  i2 ();
  digit_serial_addsub_if #(.WIDTH(32)) i3 ();

  assign i0.start = st[0];
  assign i1.start = st[1];
  assign i2.start = st[2];
  assign i3.start = st[3];
  assign i0.sub = s;
  assign i1.sub = s;
  assign i2.sub = s;
  assign i3.sub = s;
  assign i0.x = xv[7:0];
  assign i0.y = yv[7:0];
  assign i1.x = xv[15:0];
  assign i1.y = yv[15:0];
  assign i2.x = xv[7:0];
  assign i2.y = yv[7:0];
  assign i3.x = xv;
  assign i3.y = yv;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2))
    u0 (.clk(clk), .rst_b(rst_b), .bus(i0));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4))
    u1 (.clk(clk), .rst_b(rst_b), .bus(i1));
  digit_serial_addsub #(.WIDTH(8), .DIGIT(8))
    u2 (.clk(clk), .rst_b(rst_b), .bus(i2));
  digit_serial_addsub #(.WIDTH(32), .DIGIT(1))
    u3 (.clk(clk), .rst_b(rst_b), .bus(i3));

  function automatic logic [31:0] osum(int k);
    case (k)
      0: return {24'd0, i0.sum};
      1: return {16'd0, i1.sum};
      2: return {24'd0, i2.sum};
      default: return i3.sum;
    endcase
  endfunction

  function automatic logic [3:0] ofl(int k);
    case (k)
      0: return {i0.carry_out, i0.overflow,
                 i0.zero, i0.negative};
      1: return {i1.carry_out, i1.overflow,
                 i1.zero, i1.negative};
      2: return {i2.carry_out, i2.overflow,
                 i2.zero, i2.negative};
      default: return {i3.carry_out, i3.overflow,
                       i3.zero, i3.negative};
    endcase
  endfunction

  function automatic logic odone(int k);
    case (k)
      0: return i0.done;
      1: return i1.done;
      2: return i2.done;
      default: return i3.done;
    endcase
  endfunction

  function automatic logic obusy(int k);
    case (k)
      0: return i0.busy;
      1: return i1.busy;
      2: return i2.busy;
      default: return i3.busy;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic run(input int k, input logic sv,
                     input logic [31:0] xa,
                     input logic [31:0] ya,
                     input logic [31:0] es,
                     input logic [3:0] ef,
                     input int lat,
                     input string tag);
    int n;
    @(negedge clk);
    st[k] = 1'b1;
    s = sv;
    xv = xa;
    yv = ya;
    @(negedge clk);
    st[k] = 1'b0;
    n = 0;
    chk({tag, "_busy"}, 32'(obusy(k)), 32'd1);
    while (!odone(k) && n < lat + 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_sum"}, osum(k), es);
    chk({tag, "_flags"}, 32'(ofl(k)), 32'(ef));
    chk({tag, "_busy_dn"}, 32'(obusy(k)), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(odone(k)), 32'd0);
    chk({tag, "_hold"}, osum(k), es);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_sum", osum(0), 32'd0);
    chk("rst_flags", 32'(ofl(0)), 32'd0);
    chk("rst_busy", 32'(obusy(0)), 32'd0);
    chk("rst_done", 32'(odone(0)), 32'd0);
    rst_b = 1'b1;

    run(0, 0, 5, 3, 8, 4'b0000, 4, "add5_3");
    run(0, 1, 5, 3, 2, 4'b1000, 4, "sub5_3");
    run(0, 1, 0, 1, 255, 4'b0001, 4, "sub0_1");
    run(0, 0, 127, 1, 128, 4'b0101, 4, "ovf_add");
    run(0, 1, 128, 1, 127, 4'b1100, 4, "ovf_sub");
    run(0, 1, 3, 3, 0, 4'b1010, 4, "zero");
    run(0, 0, 200, 100, 44, 4'b1000, 4, "wrap");

    // start held with changing operands, then back-to-back issue
    @(negedge clk);
    st[0] = 1'b1;
    s = 1'b0;
    xv = 9;
    yv = 6;
    @(negedge clk);
    n = 0;
    while (!odone(0) && n < 12) begin
      xv = 50 + n;
      yv = 60 + n;
      @(negedge clk);
      n++;
    end
    chk("held_lat", 32'(n), 32'd4);
    chk("held_sum", osum(0), 32'd15);
    chk("held_flags", 32'(ofl(0)), 32'd0);
    xv = 10;
    yv = 20;
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_busy", 32'(obusy(0)), 32'd1);
    chk("b2b_sum_stable", osum(0), 32'd15);
    n = 0;
    while (!odone(0) && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat", 32'(n), 32'd4);
    chk("b2b_sum", osum(0), 32'd30);

    // reset after two digits aborts the operation
    @(negedge clk);
    st[0] = 1'b1;
    xv = 100;
    yv = 27;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("abort_busy", 32'(obusy(0)), 32'd0);
    chk("abort_done", 32'(odone(0)), 32'd0);
    chk("abort_sum", osum(0), 32'd0);
    chk("abort_flags", 32'(ofl(0)), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (odone(0)) n++;
    end
    chk("abort_nodone", 32'(n), 32'd0);
    run(0, 0, 100, 27, 127, 4'b0000, 4, "post_rst");

    run(1, 0, 32'h1234, 32'h4321, 32'h5555,
        4'b0000, 4, "w16_add");
    run(1, 1, 32'h8000, 32'h0001, 32'h7fff,
        4'b1100, 4, "w16_ovf");
    run(1, 0, 32'hffff, 32'h0001, 32'h0000,
        4'b1010, 4, "w16_zero");

    run(2, 0, 100, 100, 200, 4'b0101, 1, "d8_ovf");
    run(2, 1, 7, 9, 254, 4'b0001, 1, "d8_neg");
    run(2, 1, 128, 128, 0, 4'b1010, 1, "d8_zero");

    run(3, 0, 32'hffffffff, 32'hffffffff,
        32'hfffffffe, 4'b1001, 32, "w32_m1");
    run(3, 0, 32'h7fffffff, 32'h00000001,
        32'h80000000, 4'b0101, 32, "w32_ovf");
    run(3, 1, 32'h00000010, 32'h00000020,
        32'hfffffff0, 4'b0001, 32, "w32_sub");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Multi-cycle, digit-serial two's-complement adder/subtractor for the ALU datapath. It processes DIGIT bits per clock from LSB to MSB, so the carry chain is only DIGIT bits long. It uses a start/busy/done handshake and registers the result with carry, overflow, zero and negative flags. It sits alongside the combinational adder and serves area-constrained and wide-operand configurations.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH evenly.
- NDIG (local), WIDTH/DIGIT, number of digit cycles.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = x+y, 1 = x−y (computed as x + ~y + 1); sampled with start.
- x  input  WIDTH  operand A; sampled with start.
- y  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.
- negative  output  1  sum[WIDTH-1].

Behaviour:
- Reset (rst_b low, asynchronous): state = IDLE. busy, done, sum, carry_out, overflow, zero and negative all 0. Internal operand, carry and counter registers cleared. A reset during RUN aborts the operation; no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch A=x and B = sub ? ~y : y;
  - carry = sub;
  - digit counter = 0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - {c, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry;
  - shift A and B right by DIGIT;
  - shift d into the result shift register from the MSB side;
  - carry = c; counter += 1.
  - On the digit with counter == NDIG−1, also capture the carry into bit WIDTH−1 (cin_msb). At that edge, go to DONE.
- start, x, y and sub are ignored while in RUN. There is no queueing.
- On entry to DONE, the output registers are loaded from the completed shift register and final carry:
  - sum = result shift register;
  - carry_out = final carry;
  - overflow = carry_out XOR cin_msb;
  - zero = (sum == 0);
  - negative = sum[WIDTH-1].
- DONE lasts one cycle with done=1 and busy=0.
  - If start=1 at that edge: latch new operands and go to RUN (back-to-back issue).
  - Otherwise go to IDLE.
- Outputs sum and flags hold their values until the next entry to DONE or reset. They never change mid-operation.
- Latency: start sampled at edge 0 gives done=1 in the cycle after edge NDIG. Example: WIDTH=8, DIGIT=2 gives 4 cycles. Throughput is one result per NDIG cycles when back-to-back.
- When DIGIT == WIDTH, NDIG = 1: a single RUN cycle, so the result arrives 1 cycle after start.
- Width rules: no internal widening beyond DIGIT+1 bits per digit step. sum is truncated to WIDTH bits.

Test Plan:
1. WIDTH=8, DIGIT=2, x=5, y=3, sub=0, pulse start → busy for 4 cycles, then done pulse. sum=8, carry_out=0, overflow=0, zero=0, negative=0.
2. x=5, y=3, sub=1 → sum=2, carry_out=1, overflow=0. Then x=0, y=1, sub=1 → sum=255, carry_out=0, negative=1, overflow=0.
3. x=127, y=1, sub=0 → sum=128, overflow=1, negative=1, carry_out=0. Then x=128, y=1, sub=1 → sum=127, overflow=1, carry_out=1. Then x=3, y=3, sub=1 → sum=0, zero=1.
4. Hold start=1 with changing x/y during RUN → those values are ignored; the result matches the operands latched at the first start. In DONE, start with x=10, y=20 → RUN resumes immediately; the next done arrives 4 cycles later with sum=30.
5. Assert rst_b low mid-RUN (after digit 2) → all outputs 0 immediately, state IDLE, no done pulse. A new start after reset computes correctly.
6. Parameter sweep WIDTH∈{8,16,32}, DIGIT∈{1,4,WIDTH}: random x, y, sub compared against the reference (x ± y) mod 2^WIDTH and flags. done arrives exactly NDIG cycles after start.
